// File: rtl/mult_pkg.sv
// Shared constants and state type for the sequential multiplier.
// MULT_RADIX4_EN selects 2 multiplier bits per RUN cycle instead of 1.
package mult_pkg;
  localparam int WIDTH = 32;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

`ifdef MULT_RADIX4_EN
  localparam int RADIX_BITS = 2;
`else
  localparam int RADIX_BITS = 1;
`endif
  localparam int ITERS = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(ITERS + 1);
endpackage

// File: rtl/mult_seq_if.sv
// Request/result bundle between the datapath controller and mult_seq.
interface mult_seq_if #(parameter int W = mult_pkg::WIDTH);
  logic           start;
  logic           mult_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic [2*W-1:0] z;

  modport master (output start, mult_signed, a, b, input busy, z);
  modport slave  (input start, mult_signed, a, b, output busy, z);
endinterface

// File: rtl/mult_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module mult_abs #(parameter int W = 32) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add 32x32->64 multiplier (MULT/MULTU) with final sign fix.
// Build option MULT_RADIX4_EN: radix-4 RUN loop, same results in half the cycles.
module mult_seq
  import mult_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mult_seq_if.slave bus
);
  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   z_q, z_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   z_fix, addend;

  mult_abs #(.W(WIDTH)) u_abs_a (
    .x(bus.a), .neg(bus.mult_signed & bus.a[WIDTH-1]), .y(a_mag));
  mult_abs #(.W(WIDTH)) u_abs_b (
    .x(bus.b), .neg(bus.mult_signed & bus.b[WIDTH-1]), .y(b_mag));
  mult_abs #(.W(2*WIDTH)) u_fix (
    .x(acc_q), .neg(neg_q), .y(z_fix));

`ifdef MULT_RADIX4_EN
  always_comb begin
    addend = '0;
    case (mplier_q[1:0])
      2'd1:    addend = mcand_q;
      2'd2:    addend = mcand_q << 1;
      2'd3:    addend = (mcand_q << 1) + mcand_q;
      default: addend = '0;
    endcase
  end
`else
  assign addend = mplier_q[0] ? mcand_q : '0;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    z_d      = z_q;
    case (state_q)
      IDLE: if (bus.start) begin
        mcand_d  = {{WIDTH{1'b0}}, a_mag};
        mplier_d = b_mag;
        neg_d    = bus.mult_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        acc_d    = '0;
        cnt_d    = '0;
        busy_d   = 1'b1;
        state_d  = RUN;
      end
      // multiplicand walks left, multiplier walks right; LSBs pick the addend
      RUN: begin
        acc_d    = acc_q + addend;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        z_d     = z_fix;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      z_q      <= z_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.z    = z_q;
endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: hand-computed products, latency, handshake and reset.
module tb_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  always #5 clk = ~clk;

  mult_seq_if #(.W(32)) bus ();
  mult_seq dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation; optionally pulse start again at RUN cycle poke_at (0 = never).
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp, input int poke_at);
    logic [63:0] zprev;
    logic        zchg;
    int          cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.mult_signed = sgn;
    zprev = bus.z;
    zchg  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.mult_signed = ~sgn;
    check({tag, " busy_rise"}, {63'd0, bus.busy}, 64'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == poke_at);
      if (bus.busy === 1'b1 && bus.z !== zprev) zchg = 1'b1;
    end while (bus.busy === 1'b1 && cyc < 200);
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'(LAT));
    check({tag, " z"}, bus.z, exp);
    check({tag, " z_stable"}, {63'd0, zchg}, 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.mult_signed = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset z", bus.z, 64'd0);
    rst = 1'b1;

    run_op("signed",    32'hFFFF3F3F, 32'hFFFF7F7F, 1'b1, 64'h0000000060C1A141, 0);
    run_op("unsigned",  32'hFFFF3F3F, 32'hFFFF7F7F, 1'b0, 64'hFFFEBEBE60C1A141, 0);
    run_op("small_s",   32'h00000111, 32'h00000777, 1'b1, 64'h000000000007F5E7, 0);
    run_op("small_u",   32'h00000111, 32'h00000777, 1'b0, 64'h000000000007F5E7, 0);
    run_op("min_sq",    32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 0);
    run_op("m1_x_1",    32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF, 0);
    run_op("max_x_min", 32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000, 0);
    run_op("u_max_sq",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 0);
    run_op("zero_neg",  32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000, 0);
    run_op("min_x_m1",  32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000, 0);
    // new operands pushed mid-RUN must be ignored
    run_op("poke",      32'h00000111, 32'h00000777, 1'b0, 64'h000000000007F5E7, 5);

    // abort mid-RUN
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h12345678; bus.b = 32'h9ABCDEF0; bus.mult_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort z", bus.z, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 32'hFFFF3F3F, 32'hFFFF7F7F, 1'b1, 64'h0000000060C1A141, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
